// File: rtl/dbg_host_loader_if.sv
// Byte-stream link between dbg_host_loader and the uart pair.
// master: the host loader (drives tx_data/tx_valid and rx_ready).
// slave:  the uart side (drives tx_ready and rx_data/rx_valid).
interface dbg_host_loader_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        input  rx_ready
    );
endinterface

// File: rtl/dbg_host_loader.sv
// Host-side initiator for the UART debug command protocol. Loads a ROM image into the
// target (0xAA writes), runs it (0xCC), waits run_cycles, halts it (0xDD) and reads one
// register back (0xBB).
// Optional feature macro: DBG_HOST_RESET_EN -- when defined, each sequence starts with a
// 0xEE reset command that must be acknowledged before loading.
module dbg_host_loader #(
    parameter int unsigned ROM_AW      = 8,
    parameter int unsigned ADDR_SHIFT  = 2,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ROM_AW:0]      prog_words,
    input  logic [31:0]          run_cycles,
    input  logic [4:0]           reg_sel,
    output logic [ROM_AW-1:0]    rom_addr,
    input  logic [31:0]          rom_data,
    dbg_host_loader_if.master    link,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [31:0]          reg_value
);

    localparam logic [7:0]  CmdWrite   = 8'hAA;
    localparam logic [7:0]  CmdRead    = 8'hBB;
    localparam logic [7:0]  CmdRun     = 8'hCC;
    localparam logic [7:0]  CmdHalt    = 8'hDD;
`ifdef DBG_HOST_RESET_EN
    localparam logic [7:0]  CmdReset   = 8'hEE;
`endif
    localparam logic [1:0]  ErrNone    = 2'd0;
    localparam logic [1:0]  ErrAck     = 2'd1;
    localparam logic [1:0]  ErrTimeout = 2'd2;
    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        StIdle,
`ifdef DBG_HOST_RESET_EN
        StRstTx,
        StRstAck,
`endif
        StLoadChk,
        StRomRd,
        StWrTx,
        StWrAck,
        StRunTx,
        StRunAck,
        StRunWait,
        StHaltTx,
        StHaltAck,
        StRdTx,
        StRdRx,
        StDone,
        StErr
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [2:0]      byte_q, byte_d;
    logic [ROM_AW:0] idx_q, idx_d;
    logic [31:0]     word_q, word_d;
    logic [ROM_AW:0] prog_words_q, prog_words_d;
    logic [31:0]     run_cycles_q, run_cycles_d;
    logic [4:0]      reg_sel_q, reg_sel_d;
    logic [31:0]     reg_value_q, reg_value_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [1:0]      err_code_q, err_code_d;

    logic [15:0]     wr_addr;
    logic [7:0]      wr_byte;
    logic            in_wait;
    logic            ack_bad;

    // Target byte address of the current word; upper bits beyond 16 are dropped.
    assign wr_addr = 16'(32'(idx_q) << ADDR_SHIFT);

    assign rom_addr  = idx_q[ROM_AW-1:0];
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign reg_value = reg_value_q;

    // Select the byte of the 7-byte write command being presented.
    always_comb begin
        wr_byte = word_q[7:0];
        case (byte_q)
            3'd0:    wr_byte = CmdWrite;
            3'd1:    wr_byte = wr_addr[15:8];
            3'd2:    wr_byte = wr_addr[7:0];
            3'd3:    wr_byte = word_q[31:24];
            3'd4:    wr_byte = word_q[23:16];
            3'd5:    wr_byte = word_q[15:8];
            default: wr_byte = word_q[7:0];
        endcase
    end

    // Next-state, link outputs and datapath updates.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        byte_d        = byte_q;
        idx_d         = idx_q;
        word_d        = word_q;
        prog_words_d  = prog_words_q;
        run_cycles_d  = run_cycles_q;
        reg_sel_d     = reg_sel_q;
        reg_value_d   = reg_value_q;
        done_d        = done_q;
        error_d       = error_q;
        err_code_d    = err_code_q;
        link.tx_valid = 1'b0;
        link.tx_data  = 8'h00;
        link.rx_ready = 1'b0;
        in_wait       = 1'b0;
        ack_bad       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Stray bytes are drained while idle.
                link.rx_ready = 1'b1;
                if (start) begin
                    prog_words_d = prog_words;
                    run_cycles_d = run_cycles;
                    reg_sel_d    = reg_sel;
                    idx_d        = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    err_code_d   = ErrNone;
`ifdef DBG_HOST_RESET_EN
                    state_d      = StRstTx;
`else
                    state_d      = StLoadChk;
`endif
                end
            end
`ifdef DBG_HOST_RESET_EN
            StRstTx: begin
                link.tx_valid = 1'b1;
                link.tx_data  = CmdReset;
                if (link.tx_ready) state_d = StRstAck;
            end
            StRstAck: begin
                link.rx_ready = 1'b1;
                in_wait       = 1'b1;
                if (link.rx_valid) begin
                    if (link.rx_data == CmdReset) state_d = StLoadChk;
                    else                          ack_bad = 1'b1;
                end
            end
`endif
            StLoadChk: begin
                if (idx_q == prog_words_q) state_d = StRunTx;
                else                       state_d = StRomRd;
            end
            StRomRd: begin
                // rom_addr has been stable since LOAD_CHK, so rom_data is valid now.
                word_d  = rom_data;
                state_d = StWrTx;
            end
            StWrTx: begin
                link.tx_valid = 1'b1;
                link.tx_data  = wr_byte;
                if (link.tx_ready) begin
                    if (byte_q == 3'd6) state_d = StWrAck;
                    else                byte_d  = byte_q + 3'd1;
                end
            end
            StWrAck: begin
                link.rx_ready = 1'b1;
                in_wait       = 1'b1;
                if (link.rx_valid) begin
                    if (link.rx_data == CmdWrite) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StLoadChk;
                    end else begin
                        ack_bad = 1'b1;
                    end
                end
            end
            StRunTx: begin
                link.tx_valid = 1'b1;
                link.tx_data  = CmdRun;
                if (link.tx_ready) state_d = StRunAck;
            end
            StRunAck: begin
                link.rx_ready = 1'b1;
                in_wait       = 1'b1;
                if (link.rx_valid) begin
                    if (link.rx_data != CmdRun)    ack_bad = 1'b1;
                    else if (run_cycles_q == '0)   state_d = StHaltTx;
                    else                           state_d = StRunWait;
                end
            end
            StRunWait: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == run_cycles_q - 32'd1) state_d = StHaltTx;
            end
            StHaltTx: begin
                link.tx_valid = 1'b1;
                link.tx_data  = CmdHalt;
                if (link.tx_ready) state_d = StHaltAck;
            end
            StHaltAck: begin
                link.rx_ready = 1'b1;
                in_wait       = 1'b1;
                if (link.rx_valid) begin
                    if (link.rx_data == CmdHalt) state_d = StRdTx;
                    else                         ack_bad = 1'b1;
                end
            end
            StRdTx: begin
                link.tx_valid = 1'b1;
                link.tx_data  = (byte_q == 3'd0) ? CmdRead : {3'b000, reg_sel_q};
                if (link.tx_ready) begin
                    if (byte_q == 3'd1) state_d = StRdRx;
                    else                byte_d  = byte_q + 3'd1;
                end
            end
            StRdRx: begin
                link.rx_ready = 1'b1;
                in_wait       = 1'b1;
                if (link.rx_valid) begin
                    reg_value_d = {reg_value_q[23:0], link.rx_data};
                    cnt_d       = '0;
                    if (byte_q == 3'd3) state_d = StDone;
                    else                byte_d  = byte_q + 3'd1;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StErr: begin
                error_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Shared response supervision for every state that waits on the target.
        if (ack_bad) begin
            state_d    = StErr;
            err_code_d = ErrAck;
        end else if (in_wait && !link.rx_valid) begin
            if (cnt_q == TimeoutLast) begin
                state_d    = StErr;
                err_code_d = ErrTimeout;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        // Every state entry restarts the cycle and byte counters.
        if (state_d != state_q) begin
            cnt_d  = '0;
            byte_d = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Counters, sampled sequence parameters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            byte_q       <= '0;
            idx_q        <= '0;
            word_q       <= '0;
            prog_words_q <= '0;
            run_cycles_q <= '0;
            reg_sel_q    <= '0;
            reg_value_q  <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ErrNone;
        end else begin
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            prog_words_q <= prog_words_d;
            run_cycles_q <= run_cycles_d;
            reg_sel_q    <= reg_sel_d;
            reg_value_q  <= reg_value_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
        end
    end

endmodule
